patch_sum_window: RTL and testbench

//  Streaming patch summer; parametrised successor to the fixed 17-sample ring summer.

---
 rtl/patch_sum_window.sv | 205 ++++++++++++++++++++
 tb/tb_patch_sum_window.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/patch_sum_window.sv
// patch_sum_window: streaming patch summer.
//   Each accepted beat carries NS samples (one patch column). Stage 1 sums the column.
//   Stage 2 keeps a sliding window of the last PATCH_W column sums within the current
//   image row and emits one patch sum for each window position.
// Ports:
//   clk, rst (synchronous, active-low)
//   valid_i, done_i, samples_i[NS*DW]      upstream beat, frame-close request
//   sum_o[SUM_W], valid_o                  patch sum, 1-cycle strobe
//   busy_o                                 high while filling or running a row
//   progress_done_o                        1-cycle pulse when the frame closes
// Optional feature (macro PATCH_SUM_THRESH_EN):
//   adds thr_i[SUM_W] and bit_o = (patch sum >= thr_i), qualified by valid_o.
module patch_sum_window #(
  parameter  int unsigned DW      = 8,
  parameter  int unsigned NS      = 17,
  parameter  int unsigned PATCH_W = 3,
  parameter  int unsigned COLS    = 19,
  parameter  int unsigned ROWS    = 19,
  localparam int unsigned SUM_W   = DW + $clog2(NS * PATCH_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_i,
  input  logic               done_i,
  input  logic [NS*DW-1:0]   samples_i,
`ifdef PATCH_SUM_THRESH_EN
  input  logic [SUM_W-1:0]   thr_i,
  output logic               bit_o,
`endif
  output logic [SUM_W-1:0]   sum_o,
  output logic               valid_o,
  output logic               busy_o,
  output logic               progress_done_o
);

  localparam int unsigned CSW = DW + $clog2(NS);
  localparam int unsigned CW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned RW  = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_DONE
  } state_t;

  state_t                          state_q, state_d;
  logic [CW-1:0]                   col_q, col_d;
  logic [RW-1:0]                   row_q, row_d;
  logic                            busy_q, busy_d;
  logic                            prog_q, prog_d;

  // Stage 1 registers
  logic [CSW-1:0]                  colsum_q, colsum_d;
  logic                            v1_q, v1_d;
  logic                            emit1_q, emit1_d;
  logic                            first1_q, first1_d;

  // Stage 2 registers
  logic [PATCH_W-1:0][CSW-1:0]     hist_q, hist_d;
  logic [SUM_W-1:0]                win_q, win_d;
  logic                            valid_q, valid_d;

  logic [CSW-1:0]                  colsum_c;
  logic                            accept_c;
  logic                            last_col_c;
  logic                            last_row_c;
  logic                            emit_c;

  // Column sum of the incoming beat
  always_comb begin
    colsum_c = '0;
    for (int k = 0; k < int'(NS); k++) begin
      colsum_c = colsum_c + CSW'(samples_i[k*DW +: DW]);
    end
  end

  // Beats arriving during the single DONE cycle are not part of any frame and are dropped.
  assign accept_c   = valid_i && (state_q != S_DONE);
  assign last_col_c = (col_q == CW'(COLS - 1));
  assign last_row_c = (row_q == RW'(ROWS - 1));
  // Beat completes a window once at least PATCH_W columns of this row have arrived.
  assign emit_c     = (32'(col_q) + 32'd1) >= 32'(PATCH_W);

  // Frame/row sequencing
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      S_DONE: state_d = S_IDLE;
      default: begin
        if (accept_c) begin
          if (last_col_c) begin
            col_d = '0;
            if (last_row_c) begin
              row_d   = '0;
              state_d = S_DONE;
            end else begin
              row_d   = row_q + RW'(1);
              state_d = S_FILL;
            end
          end else begin
            col_d   = col_q + CW'(1);
            state_d = emit_c ? S_RUN : S_FILL;
          end
        end
        if (done_i && (state_q != S_IDLE)) begin
          state_d = S_DONE;
          col_d   = '0;
          row_d   = '0;
        end
      end
    endcase
    busy_d = (state_d == S_FILL) || (state_d == S_RUN);
    prog_d = (state_q == S_DONE);
  end

  // Stage 1: capture column sum and per-beat qualifiers
  always_comb begin
    v1_d     = accept_c;
    emit1_d  = accept_c && emit_c;
    first1_d = (col_q == '0);
    colsum_d = accept_c ? colsum_c : colsum_q;
  end

  // Stage 2: sliding window; the first column of a row restarts the window from scratch,
  // so nothing carries over from the previous row or an aborted frame.
  always_comb begin
    hist_d  = hist_q;
    win_d   = win_q;
    valid_d = 1'b0;
    if (v1_q) begin
      hist_d[0] = colsum_q;
      for (int i = 1; i < int'(PATCH_W); i++) begin
        hist_d[i] = first1_q ? '0 : hist_q[i-1];
      end
      // Intermediate may wrap; the final value is always in range, so modular math is exact.
      win_d   = first1_q ? SUM_W'(colsum_q)
                         : win_q + SUM_W'(colsum_q) - SUM_W'(hist_q[PATCH_W-1]);
      valid_d = emit1_q;
    end
  end

`ifdef PATCH_SUM_THRESH_EN
  logic bit_q, bit_d;

  // Threshold compare on the new window sum, updated with sum_o
  always_comb begin
    bit_d = bit_q;
    if (v1_q) begin
      bit_d = (win_d >= thr_i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_q <= 1'b0;
    end else begin
      bit_q <= bit_d;
    end
  end

  assign bit_o = bit_q;
`else
  // Threshold compare not built.
`endif

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      col_q    <= '0;
      row_q    <= '0;
      busy_q   <= 1'b0;
      prog_q   <= 1'b0;
      colsum_q <= '0;
      v1_q     <= 1'b0;
      emit1_q  <= 1'b0;
      first1_q <= 1'b0;
      hist_q   <= '0;
      win_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      busy_q   <= busy_d;
      prog_q   <= prog_d;
      colsum_q <= colsum_d;
      v1_q     <= v1_d;
      emit1_q  <= emit1_d;
      first1_q <= first1_d;
      hist_q   <= hist_d;
      win_q    <= win_d;
      valid_q  <= valid_d;
    end
  end

  assign sum_o           = win_q;
  assign valid_o         = valid_q;
  assign busy_o          = busy_q;
  assign progress_done_o = prog_q;

endmodule

// File: tb/tb_patch_sum_window.sv
// Scoreboard bench for patch_sum_window at default parameters.
module tb_patch_sum_window;

  localparam int unsigned DW    = 8;
  localparam int unsigned NS    = 17;
  localparam int unsigned SUM_W = 14;
  localparam int          THR   = 6630;

  typedef struct {
    int sum;
    int cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             valid_i;
  logic             done_i;
  logic [NS*DW-1:0] samples_i;
  logic [SUM_W-1:0] sum_o;
  logic             valid_o;
  logic             busy_o;
  logic             progress_done_o;
`ifdef PATCH_SUM_THRESH_EN
  logic [SUM_W-1:0] thr_i;
  logic             bit_o;
`endif

  patch_sum_window dut (
    .clk             (clk),
    .rst             (rst),
    .valid_i         (valid_i),
    .done_i          (done_i),
    .samples_i       (samples_i),
`ifdef PATCH_SUM_THRESH_EN
    .thr_i           (thr_i),
    .bit_o           (bit_o),
`endif
    .sum_o           (sum_o),
    .valid_o         (valid_o),
    .busy_o          (busy_o),
    .progress_done_o (progress_done_o)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   n_valid = 0;
  exp_t sb[$];
  int   pq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NS*DW-1:0] fill(input int v);
    logic [NS*DW-1:0] r;
    for (int k = 0; k < int'(NS); k++) r[k*DW +: DW] = DW'(v);
    return r;
  endfunction

  function automatic logic [NS*DW-1:0] fill_k(input int c);
    logic [NS*DW-1:0] r;
    for (int k = 0; k < int'(NS); k++) r[k*DW +: DW] = DW'(k * c);
    return r;
  endfunction

  // One beat; expected output and frame-close pulse are due two cycles after issue.
  task automatic beat(input logic [NS*DW-1:0] s, input bit dn, input bit ev, input int es,
                      input bit ep);
    exp_t e;
    valid_i   = 1'b1;
    done_i    = dn;
    samples_i = s;
    if (ev) begin
      e.sum = es;
      e.cyc = cyc + 2;
      sb.push_back(e);
    end
    if (ep) pq.push_back(cyc + 2);
    @(posedge clk); #1;
    valid_i = 1'b0;
    done_i  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes
  always @(negedge clk) begin
    exp_t e;
    int   p;
    if (valid_o) begin
      n_valid++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got sum %0d with empty scoreboard (cycle %0d)", sum_o, cyc);
      end else begin
        e = sb.pop_front();
        chk("sum", int'(sum_o), e.sum);
        chk("latency_cycle", cyc, e.cyc);
`ifdef PATCH_SUM_THRESH_EN
        chk("thresh_bit", int'(bit_o), (e.sum >= THR) ? 1 : 0);
`endif
      end
    end
    if (progress_done_o) begin
      if (pq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_progress: got pulse with none expected (cycle %0d)", cyc);
      end else begin
        p = pq.pop_front();
        chk("progress_cycle", cyc, p);
      end
    end
  end

  initial begin
    int n0;
    rst       = 1'b0;
    valid_i   = 1'b0;
    done_i    = 1'b0;
    samples_i = '0;
`ifdef PATCH_SUM_THRESH_EN
    thr_i     = SUM_W'(THR);
`endif
    idle(3);
    chk("reset_sum", int'(sum_o), 0);
    chk("reset_valid", int'(valid_o), 0);
    chk("reset_busy", int'(busy_o), 0);
    chk("reset_progress", int'(progress_done_o), 0);
    rst = 1'b1;
    idle(2);

    // Full frame of 255s: 323 windows of 13005, one frame-close pulse
    n0 = n_valid;
    for (int r = 0; r < 19; r++)
      for (int c = 0; c < 19; c++) begin
        beat(fill(255), 1'b0, c >= 2, 13005, (r == 18) && (c == 18));
        if (r == 9 && c == 9) chk("busy_mid_frame", int'(busy_o), 1);
      end
    chk("busy_after_frame", int'(busy_o), 0);
    idle(4);
    chk("frame_valid_count", n_valid - n0, 323);

    // Sample k = k*c: column sum 136*c; window = 136*(3c-3); frame closed by done_i at col 15
    for (int c = 0; c < 16; c++)
      beat(fill_k(c), c == 15, c >= 2, 136 * (3 * c - 3), c == 15);
    idle(4);

    // Same vectors with random idle gaps: identical sums, no strobe on idle cycles
    for (int c = 0; c < 16; c++) begin
      idle(int'($urandom_range(0, 1)));
      beat(fill_k(c), c == 15, c >= 2, 136 * (3 * c - 3), c == 15);
    end
    idle(4);

    // Row r carries value r everywhere: every window in row r sums to 51*r
    for (int r = 0; r < 19; r++)
      for (int c = 0; c < 19; c++)
        beat(fill(r), 1'b0, c >= 2, 51 * r, (r == 18) && (c == 18));
    idle(4);

    // done_i with a beat at row 5 col 10, then a clean new frame
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 19; c++)
        if (r < 5 || c <= 10)
          beat(fill(1), (r == 5) && (c == 10), c >= 2, 51, (r == 5) && (c == 10));
    idle(3);
    chk("busy_after_done", int'(busy_o), 0);
    for (int c = 0; c < 4; c++)
      beat(fill(2), c == 3, c >= 2, 102, c == 3);
    idle(4);

    // Reset at row 3: in-flight beat dropped, outputs cleared, no frame-close pulse
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 19; c++)
        if (r < 3 || c <= 4)
          beat((c % 2 == 0) ? fill(255) : fill(128), 1'b0, c >= 2,
               (c % 2 == 0) ? 17 * (255 + 128 + 255) : 17 * (128 + 255 + 128), 1'b0);
    valid_i   = 1'b1;
    samples_i = fill(200);
    @(posedge clk); #1;
    valid_i = 1'b0;
    rst     = 1'b0;
    @(posedge clk); #1;
    chk("midreset_sum", int'(sum_o), 0);
    chk("midreset_valid", int'(valid_o), 0);
    chk("midreset_busy", int'(busy_o), 0);
    idle(1);
    rst = 1'b1;
    idle(2);
    for (int c = 0; c < 4; c++)
      beat(fill(10), c == 3, c >= 2, 510, c == 3);
    idle(6);

    chk("scoreboard_drained", sb.size(), 0);
    chk("progress_drained", pq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
